dmem_responder: RTL and testbench

- Memory-side responder for the MEM-stage data-memory interface of the pipelined CPU.
- Serves load and store requests with a configurable multi-cycle latency over a req/ack handshake.
- Drives a stall signal back to the pipeline while a request is outstanding.
- Replaces the zero-latency data memory when the CPU is run against realistic memory timing.

---
 rtl/dmem_responder_pkg.sv | 17 +
 rtl/dmem_word_ram.sv | 34 +++
 rtl/dmem_responder.sv | 106 ++++++++++
 tb/tb_dmem_responder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared types, widths and helpers for the data-memory responder.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;

    function automatic int idx_w(input int depth_words);
        return (depth_words > 1) ? $clog2(depth_words) : 1;
    endfunction

endpackage

// File: rtl/dmem_word_ram.sv
// dmem_word_ram: single-port word array, synchronous write, registered read, enable-gated.
module dmem_word_ram
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          we,
    input  logic                          clr,
    input  logic [idx_w(DEPTH_WORDS)-1:0] idx,
    input  logic [WORD_W-1:0]             wdata,
    output logic [WORD_W-1:0]             rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en && we)
            mem[idx] <= wdata;
    end

    // Read register only moves on a load or a forced clear, so it holds across stores.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rdata <= '0;
        else if (clr)
            rdata <= '0;
        else if (en && !we)
            rdata <= mem[idx];
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency req/ack data-memory responder with pipeline stall.
// Define DMEM_RESPONDER_STATS_EN to add saturating load/store completion counters.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [WORD_W-1:0] addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic              ack_o,
    output logic [WORD_W-1:0] rdata_o,
    output logic              err_o,
    output logic              stall_o,
    output logic              busy_o
`ifdef DMEM_RESPONDER_STATS_EN
    ,
    output logic [15:0]       rd_cnt_o,
    output logic [15:0]       wr_cnt_o
`endif
);

    localparam int IW = idx_w(DEPTH_WORDS);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              we_q, err_q;
    logic [WORD_W-1:0] addr_q, wdata_q;
    logic              take, go_resp;
    logic              cur_we, cur_err;
    logic [WORD_W-1:0] cur_addr, cur_wdata;

    // With LATENCY=1 the commit edge is the sample edge, so the live inputs feed the array.
    always_comb begin
        take      = (state == IDLE) && req_i;
        cur_we    = take ? we_i    : we_q;
        cur_addr  = take ? addr_i  : addr_q;
        cur_wdata = take ? wdata_i : wdata_q;
        cur_err   = (cur_addr[1:0] != 2'b00) || ((cur_addr >> (IW + 2)) != '0);
        state_nx  = (state == IDLE) ? (req_i ? ((LATENCY == 1) ? RESP : WAIT) : IDLE)
                  : (state == WAIT) ? ((cnt == '0) ? RESP : WAIT)
                  : IDLE;
        cnt_nx    = take ? CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0)
                  : ((state == WAIT) && (cnt != '0)) ? cnt - CNT_W'(1)
                  : cnt;
        go_resp   = (state_nx == RESP);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (take) begin
                we_q    <= we_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
            end
            if (go_resp)
                err_q <= cur_err;
        end
    end

    dmem_word_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk  (clk_i),
        .rst_n(rst_i),
        .en   (go_resp && !cur_err),
        .we   (cur_we),
        .clr  (go_resp && cur_err),
        .idx  (cur_addr[IW+1:2]),
        .wdata(cur_wdata),
        .rdata(rdata_o)
    );

    assign ack_o   = (state == RESP);
    assign err_o   = ack_o && err_q;
    assign busy_o  = (state != IDLE);
    assign stall_o = req_i && !ack_o;

`ifdef DMEM_RESPONDER_STATS_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_cnt_o <= '0;
            wr_cnt_o <= '0;
        end else if (ack_o && !err_q) begin
            if (!we_q && (rd_cnt_o != 16'hFFFF))
                rd_cnt_o <= rd_cnt_o + 16'd1;
            if (we_q && (wr_cnt_o != 16'hFFFF))
                wr_cnt_o <= wr_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed scoreboard bench for LATENCY=3 and LATENCY=1 responders.
module tb_dmem_responder;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        ack   [2];
    logic        err   [2];
    logic        stall [2];
    logic        busy  [2];
`ifdef DMEM_RESPONDER_STATS_EN
    logic [15:0] rdc   [2];
    logic [15:0] wrc   [2];
`endif

    typedef struct {
        logic        e;
        logic [31:0] rd;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] mem_m [int];
    logic [31:0] last_rd [2];
    int          vec  = 0;
    int          miss = 0;
    int          rd_n = 0;
    int          wr_n = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) u_lat3 (
        .clk_i(clk), .rst_i(rst_n), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
        .wdata_i(wdata[0]), .ack_o(ack[0]), .rdata_o(rdata[0]), .err_o(err[0]),
        .stall_o(stall[0]), .busy_o(busy[0])
`ifdef DMEM_RESPONDER_STATS_EN
        , .rd_cnt_o(rdc[0]), .wr_cnt_o(wrc[0])
`endif
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_lat1 (
        .clk_i(clk), .rst_i(rst_n), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
        .wdata_i(wdata[1]), .ack_o(ack[1]), .rdata_o(rdata[1]), .err_o(err[1]),
        .stall_o(stall[1]), .busy_o(busy[1])
`ifdef DMEM_RESPONDER_STATS_EN
        , .rd_cnt_o(rdc[1]), .wr_cnt_o(wrc[1])
`endif
    );

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // mode 0: plain, 1: scramble addr/wdata during WAIT, 2: drop req during WAIT
    task automatic txn(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input int mode);
        exp_t x;
        logic bad;
        logic rq;
        int   l;
        int   key;
        l   = (s == 0) ? 3 : 1;
        key = s * 4096 + int'(a[11:2]);
        bad = (a[1:0] != 2'b00) || (a >= 32'h0000_1000);
        x.e  = bad;
        x.rd = bad ? 32'h0 : (w ? last_rd[s] : mem_m[key]);
        if (!bad && w)
            mem_m[key] = d;
        last_rd[s] = x.rd;
        if (s == 0 && !bad) begin
            if (w) wr_n++;
            else   rd_n++;
        end
        sb.push_back(x);
        @(posedge clk);
        #1;
        req[s] = 1'b1; we[s] = w; addr[s] = a; wdata[s] = d;
        rq = 1'b1;
        for (int k = 0; k <= l; k++) begin
            @(negedge clk);
            chkb("ack", ack[s], k == l);
            chkb("stall", stall[s], rq && (k != l));
            chkb("busy", busy[s], k != 0);
            if (k == 1 && mode == 1) begin
                addr[s]  = a ^ 32'h4;
                wdata[s] = ~d;
            end
            if (k == 1 && mode == 2) begin
                req[s] = 1'b0;
                rq     = 1'b0;
            end
        end
        x = sb.pop_front();
        chkb("err", err[s], x.e);
        chkw("rdata", rdata[s], x.rd);
    endtask

    task automatic idle(input int s);
        @(posedge clk);
        #1;
        req[s] = 1'b0;
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            req[s] = 1'b0; we[s] = 1'b0; addr[s] = '0; wdata[s] = '0; last_rd[s] = '0;
        end
        #2 rst_n = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            chkb("rst_ack", ack[s], 1'b0);
            chkb("rst_err", err[s], 1'b0);
            chkb("rst_busy", busy[s], 1'b0);
            chkw("rst_rdata", rdata[s], 32'h0);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 0);
        txn(0, 1'b1, 32'h14, 32'hCAFEF00D, 0);
        txn(0, 1'b1, 32'h00, 32'hA5A50000, 0);
        txn(0, 1'b0, 32'h13, 32'h0, 0);
        txn(0, 1'b0, 32'h1000, 32'h0, 0);
        txn(0, 1'b1, 32'h1000, 32'h0BAD0BAD, 0);
        txn(0, 1'b0, 32'h00, 32'h0, 0);
        txn(0, 1'b1, 32'h30, 32'h12345678, 1);
        txn(0, 1'b0, 32'h30, 32'h0, 0);
        txn(0, 1'b1, 32'h38, 32'h0BADF00D, 2);
        txn(0, 1'b0, 32'h38, 32'h0, 0);
        txn(0, 1'b0, 32'h14, 32'h0, 0);
        txn(0, 1'b1, 32'h20, 32'h11112222, 0);
        idle(0);

        for (int i = 0; i < 4; i++)
            txn(1, 1'b1, 32'h40 + 32'(4 * i), 32'h5000_0000 + 32'(i * 17), 0);
        for (int i = 3; i >= 0; i--)
            txn(1, 1'b0, 32'h40 + 32'(4 * i), 32'h0, 0);
        idle(1);

        @(posedge clk);
        #1;
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h33334444;
        @(posedge clk);
        #1;
        chkb("pre_rst_busy", busy[0], 1'b1);
        #2;
        rst_n = 1'b0; req[0] = 1'b0; req[1] = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            chkb("arst_ack", ack[s], 1'b0);
            chkb("arst_err", err[s], 1'b0);
            chkb("arst_busy", busy[s], 1'b0);
            chkb("arst_stall", stall[s], 1'b0);
            chkw("arst_rdata", rdata[s], 32'h0);
            last_rd[s] = '0;
        end
        rd_n = 0;
        wr_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chkb("post_rst_ack", ack[0], 1'b0);
        end

        txn(0, 1'b0, 32'h20, 32'h0, 0);
        txn(0, 1'b0, 32'h00, 32'h0, 0);
        txn(0, 1'b1, 32'h24, 32'h24242424, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 0);
        txn(0, 1'b1, 32'h1004, 32'hFFFFFFFF, 0);
        txn(0, 1'b0, 32'h30, 32'h0, 0);
        txn(0, 1'b1, 32'h28, 32'h28282828, 0);
        txn(0, 1'b0, 32'h24, 32'h0, 0);
        idle(0);
        @(negedge clk);
`ifdef DMEM_RESPONDER_STATS_EN
        chkw("rd_cnt", 32'(rdc[0]), 32'd5);
        chkw("wr_cnt", 32'(wrc[0]), 32'd2);
        chkw("rd_cnt_model", 32'(rdc[0]), 32'(rd_n));
        chkw("wr_cnt_model", 32'(wrc[0]), 32'(wr_n));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
